// File: rtl/serial_link_credit_ctrl.sv
// Credit-based flow-control stage: gates outgoing flits on peer buffer credits, piggybacks
// returned credits on every flit and issues credit-only flits when returns pile up.
module serial_link_credit_ctrl #(
  parameter int unsigned NumCredits      = 16,
  parameter int unsigned ForceSendThresh = 8,
  parameter int unsigned PayloadWidth    = 64,
  localparam int unsigned CredW          = $clog2(NumCredits + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PayloadWidth-1:0] data_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  output logic [PayloadWidth-1:0] flit_data_o,
  output logic [CredW-1:0]        flit_credits_o,
  output logic                    flit_credit_only_o,
  output logic                    flit_valid_o,
  input  logic                    flit_ready_i,
  input  logic                    credits_in_valid_i,
  input  logic [CredW-1:0]        credits_in_i,
  input  logic                    consumed_i,
  output logic [CredW-1:0]        avail_credits_o,
  output logic [CredW-1:0]        pending_credits_o,
  output logic                    credit_err_o
);

  localparam logic [CredW-1:0] NumC   = CredW'(NumCredits);
  localparam logic [CredW-1:0] ThresC = CredW'(ForceSendThresh);

  logic [CredW-1:0]        avail_q, avail_d;
  logic [CredW-1:0]        pend_q, pend_d;
  logic                    err_q, err_d;
  logic                    out_valid_q, out_valid_d;
  logic [PayloadWidth-1:0] flit_data_q, flit_data_d;
  logic [CredW-1:0]        flit_credits_q, flit_credits_d;
  logic                    flit_co_q, flit_co_d;

  logic             load, data_load, co_load, any_load;
  logic [CredW:0]   avail_sum, pend_sum;

  assign load         = !out_valid_q || flit_ready_i;
  assign data_ready_o = load && (avail_q != '0);
  assign data_load    = data_valid_i && data_ready_o;
  assign co_load      = load && !data_load && (pend_q >= ThresC);
  assign any_load     = data_load || co_load;

  always_comb begin
    out_valid_d    = out_valid_q;
    flit_data_d    = flit_data_q;
    flit_credits_d = flit_credits_q;
    flit_co_d      = flit_co_q;
    if (data_load) begin
      out_valid_d    = 1'b1;
      flit_data_d    = data_i;
      flit_credits_d = pend_q;
      flit_co_d      = 1'b0;
    end else if (co_load) begin
      out_valid_d    = 1'b1;
      flit_data_d    = '0;
      flit_credits_d = pend_q;
      flit_co_d      = 1'b1;
    end else if (flit_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // One extra bit of headroom so overflow can be detected before clamping.
  always_comb begin
    err_d     = err_q;
    avail_sum = {1'b0, avail_q} - {{CredW{1'b0}}, data_load}
              + (credits_in_valid_i ? {1'b0, credits_in_i} : '0);
    pend_sum  = (any_load ? '0 : {1'b0, pend_q}) + {{CredW{1'b0}}, consumed_i};
    if (avail_sum > {1'b0, NumC}) begin
      avail_d = NumC;
      err_d   = 1'b1;
    end else begin
      avail_d = avail_sum[CredW-1:0];
    end
    if (pend_sum > {1'b0, NumC}) begin
      pend_d = NumC;
      err_d  = 1'b1;
    end else begin
      pend_d = pend_sum[CredW-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      avail_q        <= NumC;
      pend_q         <= '0;
      err_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      flit_data_q    <= '0;
      flit_credits_q <= '0;
      flit_co_q      <= 1'b0;
    end else begin
      avail_q        <= avail_d;
      pend_q         <= pend_d;
      err_q          <= err_d;
      out_valid_q    <= out_valid_d;
      flit_data_q    <= flit_data_d;
      flit_credits_q <= flit_credits_d;
      flit_co_q      <= flit_co_d;
    end
  end

  assign flit_valid_o       = out_valid_q;
  assign flit_data_o        = flit_data_q;
  assign flit_credits_o     = flit_credits_q;
  assign flit_credit_only_o = flit_co_q;
  assign avail_credits_o    = avail_q;
  assign pending_credits_o  = pend_q;
  assign credit_err_o       = err_q;

endmodule

// File: tb/tb_serial_link_credit_ctrl.sv
// Directed bench for serial_link_credit_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_serial_link_credit_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [63:0] data_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [63:0] flit_data_o;
  logic [4:0]  flit_credits_o;
  logic        flit_credit_only_o;
  logic        flit_valid_o;
  logic        flit_ready_i;
  logic        credits_in_valid_i;
  logic [4:0]  credits_in_i;
  logic        consumed_i;
  logic [4:0]  avail_credits_o;
  logic [4:0]  pending_credits_o;
  logic        credit_err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_link_credit_ctrl #(
    .NumCredits     (16),
    .ForceSendThresh(8),
    .PayloadWidth   (64)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .data_i            (data_i),
    .data_valid_i      (data_valid_i),
    .data_ready_o      (data_ready_o),
    .flit_data_o       (flit_data_o),
    .flit_credits_o    (flit_credits_o),
    .flit_credit_only_o(flit_credit_only_o),
    .flit_valid_o      (flit_valid_o),
    .flit_ready_i      (flit_ready_i),
    .credits_in_valid_i(credits_in_valid_i),
    .credits_in_i      (credits_in_i),
    .consumed_i        (consumed_i),
    .avail_credits_o   (avail_credits_o),
    .pending_credits_o (pending_credits_o),
    .credit_err_o      (credit_err_o)
  );

  typedef struct {
    string       name;
    logic        dv;
    logic [63:0] d;
    logic        fr;
    logic        civ;
    logic [4:0]  ci;
    logic        cons;
    logic        rdy;
    logic        fv;
    logic [63:0] fd;
    logic [4:0]  fc;
    logic        co;
    logic [4:0]  av;
    logic [4:0]  pd;
    logic        err;
  } vec_t;

  function automatic vec_t mk(string name, int dv, logic [63:0] d, int fr, int civ, int ci,
                              int cons, int rdy, int fv, logic [63:0] fd, int fc, int co,
                              int av, int pd, int err);
    vec_t v;
    v.name = name; v.dv = dv[0]; v.d = d; v.fr = fr[0]; v.civ = civ[0]; v.ci = 5'(ci);
    v.cons = cons[0]; v.rdy = rdy[0]; v.fv = fv[0]; v.fd = fd; v.fc = 5'(fc); v.co = co[0];
    v.av = 5'(av); v.pd = 5'(pd); v.err = err[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, check the combinational ready, then the state after the edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    data_valid_i       = v.dv;
    data_i             = v.d;
    flit_ready_i       = v.fr;
    credits_in_valid_i = v.civ;
    credits_in_i       = v.ci;
    consumed_i         = v.cons;
    #1;
    chk({v.name, ".data_ready"}, 64'(data_ready_o), 64'(v.rdy));
    @(posedge clk);
    #1;
    chk({v.name, ".flit_valid"}, 64'(flit_valid_o), 64'(v.fv));
    chk({v.name, ".avail"}, 64'(avail_credits_o), 64'(v.av));
    chk({v.name, ".pending"}, 64'(pending_credits_o), 64'(v.pd));
    chk({v.name, ".err"}, 64'(credit_err_o), 64'(v.err));
    if (v.fv) begin
      chk({v.name, ".flit_data"}, flit_data_o, v.fd);
      chk({v.name, ".flit_credits"}, 64'(flit_credits_o), 64'(v.fc));
      chk({v.name, ".credit_only"}, 64'(flit_credit_only_o), 64'(v.co));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    data_valid_i = 1'b0; data_i = '0; flit_ready_i = 1'b0;
    credits_in_valid_i = 1'b0; credits_in_i = '0; consumed_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.flit_valid", 64'(flit_valid_o), 64'd0);
    chk("reset.data_ready", 64'(data_ready_o), 64'd1);
    chk("reset.avail", 64'(avail_credits_o), 64'd16);
    chk("reset.pending", 64'(pending_credits_o), 64'd0);
    chk("reset.err", 64'(credit_err_o), 64'd0);
    chk("reset.flit_fields", {flit_data_o[58:0], flit_credits_o},
        64'(flit_credit_only_o));
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  vec_t tbl[8];
  localparam logic [63:0] DX = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DY = 64'h5555_6666_7777_8888;
  localparam logic [63:0] DZ = 64'h9999_aaaa_bbbb_cccc;

  initial begin
    rst_i = 1'b1;
    //            name      dv d       fr civ ci cons rdy fv fd      fc co av  pd err
    tbl[0] = mk("t_load1",  1, 64'hA1, 1, 0,  0, 0,   1,  1, 64'hA1, 0, 0, 15, 0, 0);
    tbl[1] = mk("t_cons",   1, 64'hA2, 1, 0,  0, 1,   1,  1, 64'hA2, 0, 0, 14, 1, 0);
    tbl[2] = mk("t_hold",   1, 64'hA3, 0, 0,  0, 1,   0,  1, 64'hA2, 0, 0, 14, 2, 0);
    tbl[3] = mk("t_accept", 1, 64'hA3, 1, 0,  0, 0,   1,  1, 64'hA3, 2, 0, 13, 0, 0);
    tbl[4] = mk("t_all3",   1, 64'hA4, 1, 1,  2, 1,   1,  1, 64'hA4, 0, 0, 14, 1, 0);
    tbl[5] = mk("t_drain",  0, 64'h0,  1, 0,  0, 0,   1,  0, 64'h0,  0, 0, 14, 1, 0);
    tbl[6] = mk("t_cin2",   0, 64'h0,  0, 1,  2, 0,   1,  0, 64'h0,  0, 0, 16, 1, 0);
    tbl[7] = mk("t_ovf",    0, 64'h0,  1, 1,  1, 0,   1,  0, 64'h0,  0, 0, 16, 1, 1);

    do_reset();
    for (int i = 0; i < 8; i++) run_vec(tbl[i]);
    // Error flag must stick
    run_vec(mk("t_sticky", 0, 64'h0, 1, 0, 0, 0, 1, 0, 64'h0, 0, 0, 16, 1, 1));

    // Exhaust all 16 credits back to back, then stall.
    do_reset();
    for (int i = 0; i < 16; i++)
      run_vec(mk("b2b", 1, 64'(100 + i), 1, 0, 0, 0, 1, 1, 64'(100 + i), 0, 0, 15 - i, 0, 0));
    run_vec(mk("stall17", 1, 64'hDEAD, 1, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    // Returned credits do not open ready in the same cycle.
    run_vec(mk("cin3", 1, 64'hDEAD, 1, 1, 3, 0, 0, 0, 64'h0, 0, 0, 3, 0, 0));
    for (int i = 0; i < 3; i++)
      run_vec(mk("refill", 1, 64'(200 + i), 1, 0, 0, 0, 1, 1, 64'(200 + i), 0, 0, 2 - i, 0, 0));
    run_vec(mk("stall_again", 1, 64'hDEAD, 1, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0));

    // Credit-only flit with zero send credits, consume pulse coinciding with the load.
    for (int i = 0; i < 8; i++)
      run_vec(mk("cons_acc", 0, 64'h0, 1, 0, 0, 1, 0, 0, 64'h0, 0, 0, 0, i + 1, 0));
    run_vec(mk("co_flit", 0, 64'h0, 1, 0, 0, 1, 0, 1, 64'h0, 8, 1, 0, 1, 0));
    run_vec(mk("co_done", 0, 64'h0, 1, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 1, 0));

    // Backpressure hold with consumes accumulating.
    run_vec(mk("h_cin", 0, 64'h0, 1, 1, 4, 0, 0, 0, 64'h0, 0, 0, 4, 1, 0));
    run_vec(mk("h_load", 1, DX, 1, 0, 0, 0, 1, 1, DX, 1, 0, 3, 0, 0));
    for (int i = 0; i < 5; i++)
      run_vec(mk("h_hold", 1, DY, 0, 0, 0, 1, 0, 1, DX, 1, 0, 3, i + 1, 0));
    run_vec(mk("h_accept", 1, DY, 1, 0, 0, 0, 1, 1, DY, 5, 0, 2, 0, 0));

    // Asynchronous reset while a flit is waiting.
    run_vec(mk("r_wait", 1, DZ, 0, 0, 0, 1, 0, 1, DY, 5, 0, 2, 1, 0));
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst.flit_valid", 64'(flit_valid_o), 64'd0);
    chk("async_rst.avail", 64'(avail_credits_o), 64'd16);
    chk("async_rst.pending", 64'(pending_credits_o), 64'd0);
    chk("async_rst.data_ready", 64'(data_ready_o), 64'd1);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
